// File: rtl/dmem_stage.sv
// Data-memory stage: single-port 32-bit word RAM with byte-enable writes, fixed read
// latency and one outstanding access. Define DMEM_STATS_EN to add read/write counters.
module dmem_stage #(
    parameter int dmem_addr_width_p = 10,
    parameter int mem_latency_p     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [69:0] to_mem_flat_i,
    output logic        mem_yumi_o,
    output logic [33:0] from_mem_flat_o
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0] rd_count_o,
    output logic [31:0] wr_count_o
`endif
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_WAIT    = 2'd1;
    localparam logic [1:0]  ST_RESP    = 2'd2;
    localparam int          DEPTH      = 1 << dmem_addr_width_p;
    localparam logic [2:0]  LAT_M1     = 3'(mem_latency_p - 1);
    localparam logic [31:0] RANGE_MASK = 32'hFFFF_FFFF << (dmem_addr_width_p + 2);

    logic                         req_valid;
    logic                         req_wen;
    logic [3:0]                   req_be;
    logic [31:0]                  req_addr;
    logic [31:0]                  req_wdata;
    logic                         req_err;
    logic [dmem_addr_width_p-1:0] req_idx;

    assign req_valid = to_mem_flat_i[69];
    assign req_wen   = to_mem_flat_i[68];
    assign req_be    = to_mem_flat_i[67:64];
    assign req_addr  = to_mem_flat_i[63:32];
    assign req_wdata = to_mem_flat_i[31:0];
    assign req_idx   = req_addr[dmem_addr_width_p+1:2];
    assign req_err   = (req_addr[1:0] != 2'b00) || ((req_addr & RANGE_MASK) != 32'h0);

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_we;
`ifdef DMEM_STATS_EN
    logic        resp_wen_q, resp_wen_d;
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
`endif

    // Next-state, accept handshake and response capture; reads sample the RAM in the accept cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_yumi_o   = 1'b0;
        mem_we       = 1'b0;
`ifdef DMEM_STATS_EN
        resp_wen_d   = resp_wen_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !reset) begin
                    mem_yumi_o = 1'b1;
                    mem_we     = req_wen && !req_err;
                    cnt_d      = LAT_M1;
                    resp_err_d = req_err;
`ifdef DMEM_STATS_EN
                    resp_wen_d = req_wen;
`endif
                    if (req_wen || req_err) begin
                        resp_rdata_d = 32'h0;
                    end else begin
                        resp_rdata_d = mem[req_idx];
                    end
                    if (LAT_M1 != 3'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DMEM_STATS_EN
    // Count only error-free accesses, in their response cycle.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == ST_RESP && !resp_err_q) begin
            if (resp_wen_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end else begin
            rd_count_d = rd_count_q;
        end
    end

    // Statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
`endif

    // Control and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
`ifdef DMEM_STATS_EN
            resp_wen_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef DMEM_STATS_EN
            resp_wen_q   <= resp_wen_d;
`endif
        end
    end

    // RAM write port: commits at the accept edge and is deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (req_be[k]) begin
                    mem[req_idx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    assign from_mem_flat_o = (state_q == ST_RESP && !reset) ?
                             {1'b1, resp_err_q, resp_rdata_q} : 34'd0;

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: a latency-1 and a latency-3 instance driven from
// vector tables, with a scoreboard queue checking every response's data, error and cycle.
module tb_dmem_stage;

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [69:0] req   [2];
    logic        yumi  [2];
    logic [33:0] resp  [2];
`ifdef DMEM_STATS_EN
    logic [31:0] rd_cnt [2];
    logic [31:0] wr_cnt [2];
`endif

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_stage #(.dmem_addr_width_p(10), .mem_latency_p(1)) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .to_mem_flat_i   (req[0]),
        .mem_yumi_o      (yumi[0]),
        .from_mem_flat_o (resp[0])
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o      (rd_cnt[0]),
        .wr_count_o      (wr_cnt[0])
`endif
    );

    dmem_stage #(.dmem_addr_width_p(10), .mem_latency_p(3)) u_dut3 (
        .clk             (clk),
        .reset           (reset),
        .to_mem_flat_i   (req[1]),
        .mem_yumi_o      (yumi[1]),
        .from_mem_flat_o (resp[1])
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o      (rd_cnt[1]),
        .wr_count_o      (wr_cnt[1])
`endif
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [69:0] pack(input vec_t v);
        return {1'b1, v.wen, v.be, v.addr, v.wdata};
    endfunction

    function automatic vec_t mk(input logic wen, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.wen = wen; v.be = be; v.addr = addr; v.wdata = wdata; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic push_exp(input int d, input vec_t v);
        exp_t e;
        e.err   = v.err;
        e.rdata = v.rdata;
        e.cyc   = cyc + lat_of(d);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Checks every response against the queue and that the bus is all-zero otherwise.
    task automatic monitor();
        exp_t e;
        int   qs;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                qs = (d == 0) ? q0.size() : q1.size();
                if (resp[d][33]) begin
                    tests++;
                    if (qs == 0) begin
                        fails++;
                        $display("FAIL unexpected_resp dut%0d: got %h at cycle %0d, required no response",
                                 d, resp[d], cyc);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        if (resp[d][32] !== e.err || resp[d][31:0] !== e.rdata || cyc != e.cyc) begin
                            fails++;
                            $display("FAIL resp dut%0d: got err=%b rdata=%h cycle=%0d, required err=%b rdata=%h cycle=%0d",
                                     d, resp[d][32], resp[d][31:0], cyc, e.err, e.rdata, e.cyc);
                        end
                    end
                end else if (resp[d] !== 34'd0) begin
                    tests++;
                    fails++;
                    $display("FAIL idle_bus dut%0d: got %h, required 0", d, resp[d]);
                end
            end
        end
    endtask

    task automatic send(input int d, input vec_t v);
        bit got = 1'b0;
        int n   = 0;
        @(negedge clk);
        req[d] = pack(v);
        while (!got && n < 30) begin
            #1;
            if (yumi[d]) begin
                got = 1'b1;
                push_exp(d, v);
            end
            @(negedge clk);
            n++;
        end
        req[d] = 70'd0;
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout dut%0d addr=%h: got no yumi, required yumi", d, v.addr);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d/%0d pending, required 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    vec_t tbl [17];
    vec_t stream [6];

    initial begin
        int   idx;
        int   prev;
        int   n;

        tbl[0]  = mk(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        tbl[2]  = mk(1'b1, 4'hF, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h0);
        tbl[3]  = mk(1'b1, 4'h5, 32'h0000_0000, 32'hAABB_CCDD, 1'b0, 32'h0);
        tbl[4]  = mk(1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'h11BB_33DD);
        tbl[5]  = mk(1'b0, 4'h0, 32'h0000_0013, 32'h0,         1'b1, 32'h0);
        tbl[6]  = mk(1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0);
        tbl[7]  = mk(1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'h11BB_33DD);
        tbl[8]  = mk(1'b1, 4'hF, 32'h0000_0008, 32'h0000_0055, 1'b0, 32'h0);
        tbl[9]  = mk(1'b1, 4'h0, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'h0);
        tbl[10] = mk(1'b0, 4'h0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_0055);
        tbl[11] = mk(1'b0, 4'h0, 32'h8000_0000, 32'h0,         1'b1, 32'h0);
        tbl[12] = mk(1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0);
        tbl[13] = mk(1'b0, 4'h0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D);
        tbl[14] = mk(1'b0, 4'h0, 32'h0000_0002, 32'h0,         1'b1, 32'h0);
        tbl[15] = mk(1'b1, 4'hF, 32'h0000_0011, 32'h0BAD_0BAD, 1'b1, 32'h0);
        tbl[16] = mk(1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);

        stream[0] = mk(1'b1, 4'hF, 32'h0000_0020, 32'hA5A5_A5A5, 1'b0, 32'h0);
        stream[1] = mk(1'b1, 4'hF, 32'h0000_0024, 32'h5A5A_5A5A, 1'b0, 32'h0);
        stream[2] = mk(1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_A5A5);
        stream[3] = mk(1'b0, 4'h0, 32'h0000_0024, 32'h0,         1'b0, 32'h5A5A_5A5A);
        stream[4] = mk(1'b0, 4'h0, 32'h0000_0027, 32'h0,         1'b1, 32'h0);
        stream[5] = mk(1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_A5A5);

        reset  = 1'b1;
        req[0] = pack(tbl[1]);
        req[1] = 70'd0;
        fork
            monitor();
        join_none

        // Reset state: no yumi even with a valid request, bus idle.
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (yumi[0] !== 1'b0 || yumi[1] !== 1'b0) begin
            fails++;
            $display("FAIL reset_yumi: got %b%b, required 00", yumi[0], yumi[1]);
        end
        tests++;
        if (resp[0] !== 34'd0 || resp[1] !== 34'd0) begin
            fails++;
            $display("FAIL reset_resp: got %h/%h, required 0/0", resp[0], resp[1]);
        end
        @(negedge clk);
        req[0] = 70'd0;
        reset  = 1'b0;

        for (int i = 0; i < 17; i++) send(0, tbl[i]);
        drain();

        // Latency 3 with valid held high: one accept every 4 cycles, responses in order.
        @(negedge clk);
        idx    = 0;
        prev   = -1;
        n      = 0;
        req[1] = pack(stream[0]);
        while (idx < 6 && n < 100) begin
            #1;
            if (yumi[1]) begin
                push_exp(1, stream[idx]);
                if (prev >= 0) begin
                    tests++;
                    if (cyc - prev != 4) begin
                        fails++;
                        $display("FAIL yumi_spacing item %0d: got %0d cycles, required 4", idx, cyc - prev);
                    end
                end
                prev = cyc;
                idx++;
            end
            @(negedge clk);
            if (idx < 6) req[1] = pack(stream[idx]);
            n++;
        end
        req[1] = 70'd0;
        tests++;
        if (idx != 6) begin
            fails++;
            $display("FAIL stream_timeout: got %0d accepts, required 6", idx);
        end
        drain();

        // Reset while a latency-3 read is in WAIT: response aborted, RAM keeps prior write.
        send(1, mk(1'b1, 4'hF, 32'h0000_0040, 32'h0BAD_CAFE, 1'b0, 32'h0));
        drain();
        @(negedge clk);
        req[1] = pack(mk(1'b0, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 32'h0));
        #1;
        tests++;
        if (yumi[1] !== 1'b1) begin
            fails++;
            $display("FAIL abort_accept: got yumi=%b, required 1", yumi[1]);
        end
        @(negedge clk);
        req[1] = 70'd0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (resp[1][33] !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_resp: got valid=%b, required 0", resp[1][33]);
            end
        end
        send(1, mk(1'b0, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 32'h0BAD_CAFE));
        drain();

`ifdef DMEM_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send(0, mk(1'b1, 4'hF, 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0));
        send(0, mk(1'b1, 4'hF, 32'h0000_0104, 32'h0000_0002, 1'b0, 32'h0));
        send(0, mk(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 32'h0000_0001));
        send(0, mk(1'b0, 4'h0, 32'h0000_0104, 32'h0, 1'b0, 32'h0000_0002));
        send(0, mk(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 32'h0000_0001));
        send(0, mk(1'b0, 4'h0, 32'h0000_0101, 32'h0, 1'b1, 32'h0));
        drain();
        tests++;
        if (rd_cnt[0] !== 32'd3 || wr_cnt[0] !== 32'd2) begin
            fails++;
            $display("FAIL stats_counts: got rd=%0d wr=%0d, required rd=3 wr=2", rd_cnt[0], wr_cnt[0]);
        end
        @(negedge clk);
        force u_dut1.rd_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut1.rd_count_q;
        send(0, mk(1'b0, 4'h0, 32'h0000_0100, 32'h0, 1'b0, 32'h0000_0001));
        drain();
        tests++;
        if (rd_cnt[0] !== 32'd0) begin
            fails++;
            $display("FAIL stats_wrap: got rd=%h, required 0", rd_cnt[0]);
        end
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
